ring_phase_tracker: RTL and testbench
=====================================

Name: ring_phase_tracker

Overview:
- Downstream consumer of the 8-bit one-hot ring counter output (`out[0:7]`, driven by `clock`, seeded by `init`).
- Samples the ring vector every clock and encodes the active bit to a binary phase index.
- Checks that the ring stays one-hot and advances by exactly one position per clock; counts completed laps.
- Supplies phase/lap strobes to the sequencing logic behind it and raises sticky fault status for the system controller.

Parameters:
- RING_W, 8: ring length. Must be a power of 2, >= 4.
- PH_W, $clog2(RING_W) = 3: phase index width. Derived; not overridable.
- LOCK_LEN, 4: consecutive legal advances required to declare lock. Range 1..15.
- LAP_W, 8: lap counter width.

Ports:
- clock, input, 1: rising-edge clock, same domain as the ring counter.
- reset, input, 1: asynchronous, active-high reset.
- ring_in, input, [0:RING_W-1]: ring counter output. Bit 0 is position 0; legal rotation is position p to p+1 mod RING_W.
- clear_err, input, 1: synchronous; clears FAULT and all sticky errors.
- phase, output, PH_W: index of the active ring bit (registered).
- phase_valid, output, 1: phase is trustworthy; high only in LOCKED.
- lap_tick, output, 1: one-cycle pulse on a legal wrap from RING_W-1 to 0 while LOCKED.
- lap_count, output, LAP_W: number of completed laps while LOCKED.
- locked, output, 1: state == LOCKED.
- err_onehot, output, 1: sticky; ring_in was not one-hot while SYNC/LOCKED.
- err_seq, output, 1: sticky; illegal position jump while LOCKED.

Behaviour:
- Reset (async assert, sync release): state=IDLE, phase=0, prev_pos=0, sync_cnt=0, lap_count=0. phase_valid, lap_tick, locked, err_onehot and err_seq all 0.
- Per-edge classification of ring_in:
  - ZERO: all bits 0.
  - ONEHOT(p): exactly one bit set, at p.
  - MULTI: two or more bits set.
  - For ONEHOT(p), the move relative to prev_pos is one of:
    - ADV: p == prev_pos+1 mod RING_W.
    - RESTART: p == 0 and not ADV. This models re-`init`.
    - BAD: any other p, including p == prev_pos (stall).
- Latency: all outputs are registered and reflect ring_in sampled at the same edge (1 clock).
- phase and prev_pos load p on every ONEHOT sample in any state except FAULT. They hold otherwise.
- States (2-bit encoding): IDLE, SYNC, LOCKED, FAULT.
  - IDLE:
    - ZERO or MULTI: stay. No error; the counter is simply not initialised.
    - ONEHOT(p): go to SYNC, sync_cnt=0.
  - SYNC:
    - ADV: sync_cnt++. When sync_cnt reaches LOCK_LEN, go to LOCKED.
    - RESTART: sync_cnt=0, stay.
    - BAD: sync_cnt=0, stay. No error flagged.
    - ZERO: go to IDLE.
    - MULTI: set err_onehot, go to IDLE.
  - LOCKED:
    - ADV: stay. If prev_pos==RING_W-1, pulse lap_tick and increment lap_count. lap_count saturates at all-ones.
    - RESTART: go to SYNC, sync_cnt=0. lap_count holds; no error.
    - BAD: set err_seq, go to FAULT.
    - ZERO or MULTI: set err_onehot, go to FAULT.
  - FAULT:
    - Outputs frozen except phase_valid=0 and locked=0.
    - clear_err: go to IDLE, clear err_onehot, err_seq and lap_count.
- clear_err in IDLE/SYNC/LOCKED clears the sticky errors only; the state is unaffected.
- If clear_err and a new error occur in the same cycle, the new error wins (flag stays set).
- Reset asserted mid-operation immediately forces the reset values, regardless of state.
- lap_tick is never asserted outside LOCKED. The transition edge into LOCKED does not generate lap_tick, even on a wrap.

Decomposition:
- Shared package `ring_pkg`:
  - State enum: IDLE=2'd0, SYNC=2'd1, LOCKED=2'd2, FAULT=2'd3.
  - Classification enum: ZERO, ONEHOT, MULTI.
  - RING_W default constant.
- One sub-module: `onehot_encoder`.
  - Purely combinational: ring_in -> {is_zero, is_onehot, pos[PH_W-1:0]}.
  - pos is don't-care unless is_onehot.
- FSM, counters and sticky flags live in `ring_phase_tracker`.

Test Plan:
1. Reset, then hold ring_in=8'b0 for 10 clocks -> state IDLE, locked=0, no errors.
2. Drive a legal rotation from position 0 (one bit advancing 0,1,2,...) -> locked=1 at the edge sampling position 4. phase_valid tracks phase with 1-clock latency. lap_tick pulses on each 7->0 wrap; lap_count=3 after 3 wraps.
3. While LOCKED at position 5, force RESTART to position 0 -> state SYNC, locked=0, lap_count unchanged, no error flags. Relock after 4 advances.
4. While LOCKED at position 2, drive position 5 -> err_seq=1, FAULT, phase frozen at 2. Then clear_err -> IDLE, err_seq=0, lap_count=0.
5. While LOCKED, drive two bits set (positions 3 and 4) -> err_onehot=1, FAULT. Assert reset mid-FAULT -> all outputs return to reset values asynchronously.
6. In SYNC, stall at position 2 for 2 clocks -> sync_cnt resets, no error. Then 4 advances -> locked=1. clear_err pulse with no error pending -> state unchanged.

Source files
------------

// File: rtl/ring_pkg.sv
// Shared types for the ring phase tracker: FSM states, ring sample classes.
package ring_pkg;

  localparam int unsigned RING_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2,
    FAULT  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    ZERO   = 2'd0,
    ONEHOT = 2'd1,
    MULTI  = 2'd2
  } ring_cls_e;

  // Collapse the encoder flags into a single sample class.
  function automatic ring_cls_e classify(input logic is_zero, input logic is_onehot);
    if (is_zero) begin
      return ZERO;
    end
    if (is_onehot) begin
      return ONEHOT;
    end
    return MULTI;
  endfunction

endpackage

// File: rtl/ring_phase_tracker_onehot_encoder.sv
// Combinational one-hot detector and binary position encoder for the ring vector.
module onehot_encoder #(
  parameter  int unsigned RING_W = 8,
  localparam int unsigned PH_W   = $clog2(RING_W)
) (
  input  logic [0:RING_W-1] ring_i,
  output logic              is_zero_o,
  output logic              is_onehot_o,
  output logic [PH_W-1:0]   pos_o
);

  localparam int unsigned CNT_W = PH_W + 1;

  logic [CNT_W-1:0] ones;

  // Count set bits and OR together their indices; pos is exact only when one bit is set.
  always_comb begin
    ones  = '0;
    pos_o = '0;
    for (int i = 0; i < int'(RING_W); i++) begin
      if (ring_i[i]) begin
        ones  = ones + CNT_W'(1);
        pos_o = pos_o | PH_W'(i);
      end
    end
    is_zero_o   = (ones == '0);
    is_onehot_o = (ones == CNT_W'(1));
  end

endmodule

// File: rtl/ring_phase_tracker.sv
// Tracks a one-hot ring counter: encodes phase, checks rotation, counts laps, flags faults.
module ring_phase_tracker
  import ring_pkg::*;
#(
  parameter  int unsigned RING_W   = RING_W_DEF,
  parameter  int unsigned LOCK_LEN = 4,
  parameter  int unsigned LAP_W    = 8,
  localparam int unsigned PH_W     = $clog2(RING_W)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [0:RING_W-1] ring_in,
  input  logic              clear_err,
  output logic [PH_W-1:0]   phase,
  output logic              phase_valid,
  output logic              lap_tick,
  output logic [LAP_W-1:0]  lap_count,
  output logic              locked,
  output logic              err_onehot,
  output logic              err_seq
);

  localparam int unsigned SYNC_W = 4;

  state_e            state_q, state_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [PH_W-1:0]   prev_pos_q, prev_pos_d;
  logic [SYNC_W-1:0] sync_cnt_q, sync_cnt_d;
  logic [LAP_W-1:0]  lap_count_q, lap_count_d;
  logic              lap_tick_q, lap_tick_d;
  logic              locked_q, locked_d;
  logic              valid_q, valid_d;
  logic              err_onehot_q, err_onehot_d;
  logic              err_seq_q, err_seq_d;

  logic              is_zero;
  logic              is_onehot;
  logic [PH_W-1:0]   pos;
  ring_cls_e         cls;
  logic              adv;
  logic              restart;
  logic              wrap;
  logic              set_onehot_err;
  logic              set_seq_err;

  onehot_encoder #(
    .RING_W (RING_W)
  ) u_enc (
    .ring_i      (ring_in),
    .is_zero_o   (is_zero),
    .is_onehot_o (is_onehot),
    .pos_o       (pos)
  );

  // Sample classification and move relative to the last good position.
  always_comb begin
    cls     = classify(is_zero, is_onehot);
    adv     = (pos == PH_W'(prev_pos_q + PH_W'(1)));
    restart = (pos == '0) && !adv;
    wrap    = (prev_pos_q == PH_W'(RING_W - 1));
  end

  // Next-state, counters and sticky flags.
  always_comb begin
    state_d        = state_q;
    phase_d        = phase_q;
    prev_pos_d     = prev_pos_q;
    sync_cnt_d     = sync_cnt_q;
    lap_count_d    = lap_count_q;
    lap_tick_d     = 1'b0;
    set_onehot_err = 1'b0;
    set_seq_err    = 1'b0;

    case (state_q)
      IDLE: begin
        if (cls == ONEHOT) begin
          state_d    = SYNC;
          sync_cnt_d = '0;
        end
      end
      SYNC: begin
        case (cls)
          ONEHOT: begin
            if (adv) begin
              sync_cnt_d = sync_cnt_q + SYNC_W'(1);
              if (sync_cnt_d == SYNC_W'(LOCK_LEN)) begin
                state_d = LOCKED;
              end
            end else begin
              sync_cnt_d = '0;
            end
          end
          ZERO: begin
            state_d = IDLE;
          end
          default: begin
            set_onehot_err = 1'b1;
            state_d        = IDLE;
          end
        endcase
      end
      LOCKED: begin
        if (cls == ONEHOT) begin
          if (adv) begin
            if (wrap) begin
              lap_tick_d = 1'b1;
              if (lap_count_q != '1) begin
                lap_count_d = lap_count_q + LAP_W'(1);
              end
            end
          end else if (restart) begin
            state_d    = SYNC;
            sync_cnt_d = '0;
          end else begin
            set_seq_err = 1'b1;
            state_d     = FAULT;
          end
        end else begin
          set_onehot_err = 1'b1;
          state_d        = FAULT;
        end
      end
      default: begin
        if (clear_err) begin
          state_d     = IDLE;
          lap_count_d = '0;
        end
      end
    endcase

    // A sample that faults the tracker is not trusted, so phase keeps the last good position.
    if ((cls == ONEHOT) && (state_q != FAULT) && (state_d != FAULT)) begin
      phase_d    = pos;
      prev_pos_d = pos;
    end

    // A new error in the same cycle as clear_err keeps its flag set.
    err_onehot_d = (err_onehot_q & ~clear_err) | set_onehot_err;
    err_seq_d    = (err_seq_q & ~clear_err) | set_seq_err;

    locked_d = (state_d == LOCKED);
    valid_d  = (state_d == LOCKED);
  end

  // State and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      phase_q      <= '0;
      prev_pos_q   <= '0;
      sync_cnt_q   <= '0;
      lap_count_q  <= '0;
      lap_tick_q   <= 1'b0;
      locked_q     <= 1'b0;
      valid_q      <= 1'b0;
      err_onehot_q <= 1'b0;
      err_seq_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      prev_pos_q   <= prev_pos_d;
      sync_cnt_q   <= sync_cnt_d;
      lap_count_q  <= lap_count_d;
      lap_tick_q   <= lap_tick_d;
      locked_q     <= locked_d;
      valid_q      <= valid_d;
      err_onehot_q <= err_onehot_d;
      err_seq_q    <= err_seq_d;
    end
  end

  assign phase       = phase_q;
  assign phase_valid = valid_q;
  assign lap_tick    = lap_tick_q;
  assign lap_count   = lap_count_q;
  assign locked      = locked_q;
  assign err_onehot  = err_onehot_q;
  assign err_seq     = err_seq_q;

endmodule

// File: tb/tb_ring_phase_tracker.sv
// Self-checking bench for ring_phase_tracker: vector tables through a scoreboard queue.
module tb_ring_phase_tracker;

  localparam int unsigned RW = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic [0:RW-1] ring_in;
  logic          clear_err;
  logic [2:0]    phase;
  logic          phase_valid;
  logic          lap_tick;
  logic [7:0]    lap_count;
  logic          locked;
  logic          err_onehot;
  logic          err_seq;

  ring_phase_tracker dut (
    .clock       (clock),
    .reset       (reset),
    .ring_in     (ring_in),
    .clear_err   (clear_err),
    .phase       (phase),
    .phase_valid (phase_valid),
    .lap_tick    (lap_tick),
    .lap_count   (lap_count),
    .locked      (locked),
    .err_onehot  (err_onehot),
    .err_seq     (err_seq)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [0:RW-1] ring;
    logic          clr;
    logic [2:0]    ph;
    logic          lk;
    logic          tick;
    logic [7:0]    laps;
    logic          eo;
    logic          es;
  } vec_t;

  vec_t vec_q[$];
  vec_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic logic [0:RW-1] oh(input int p);
    logic [0:RW-1] v;
    v = '0;
    v[3'(p)] = 1'b1;
    return v;
  endfunction

  task automatic add(input logic [0:RW-1] ring, input logic clr, input int ph, input logic lk,
                     input logic tick, input int laps, input logic eo, input logic es);
    vec_t v;
    v.ring = ring;
    v.clr  = clr;
    v.ph   = 3'(ph);
    v.lk   = lk;
    v.tick = tick;
    v.laps = 8'(laps);
    v.eo   = eo;
    v.es   = es;
    vec_q.push_back(v);
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic check_outputs(input vec_t e, input string tag);
    check({tag, ".phase"},       8'(phase),       8'(e.ph));
    check({tag, ".phase_valid"}, 8'(phase_valid), 8'(e.lk));
    check({tag, ".locked"},      8'(locked),      8'(e.lk));
    check({tag, ".lap_tick"},    8'(lap_tick),    8'(e.tick));
    check({tag, ".lap_count"},   lap_count,       e.laps);
    check({tag, ".err_onehot"},  8'(err_onehot),  8'(e.eo));
    check({tag, ".err_seq"},     8'(err_seq),     8'(e.es));
  endtask

  // Drive each vector on the falling edge, compare one rising edge later.
  task automatic run_table(input string tag);
    vec_t e;
    for (int i = 0; i < vec_q.size(); i++) begin
      @(negedge clock);
      ring_in   = vec_q[i].ring;
      clear_err = vec_q[i].clr;
      sb_q.push_back(vec_q[i]);
      @(posedge clock);
      #1;
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL %s[%0d].scoreboard actual=empty required=entry", tag, i);
      end else begin
        e = sb_q.pop_front();
        check_outputs(e, $sformatf("%s[%0d]", tag, i));
      end
    end
    vec_q.delete();
    @(negedge clock);
    clear_err = 1'b0;
  endtask

  logic [0:RW-1] zero_v;
  logic [0:RW-1] multi_v;
  vec_t          rst_v;

  initial begin
    int   laps;
    logic tick;
    zero_v    = '0;
    multi_v   = oh(3) | oh(4);
    rst_v     = '{ring: '0, clr: 1'b0, ph: 3'd0, lk: 1'b0, tick: 1'b0, laps: 8'd0, eo: 1'b0, es: 1'b0};
    reset     = 1'b1;
    ring_in   = '0;
    clear_err = 1'b0;
    #1;
    check_outputs(rst_v, "reset");
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;

    // Idle with an uninitialised ring.
    for (int i = 0; i < 10; i++) add(zero_v, 0, 0, 0, 0, 0, 0, 0);

    // Legal rotation from 0, lock at position 4, three wraps.
    for (int p = 0; p < 4; p++) add(oh(p), 0, p, 0, 0, 0, 0, 0);
    add(oh(4), 0, 4, 1, 0, 0, 0, 0);
    laps = 0;
    for (int k = 5; k < 30; k++) begin
      tick = ((k % 8) == 0);
      if (tick) laps++;
      add(oh(k % 8), 0, k % 8, 1, tick, laps, 0, 0);
    end

    // Restart from position 5 back to 0, relock after four advances.
    add(oh(0), 0, 0, 0, 0, 3, 0, 0);
    for (int p = 1; p < 4; p++) add(oh(p), 0, p, 0, 0, 3, 0, 0);
    add(oh(4), 0, 4, 1, 0, 3, 0, 0);

    // Jump 2 -> 5 while locked: sequence fault, frozen, then clear.
    add(oh(5), 0, 5, 1, 0, 3, 0, 0);
    add(oh(6), 0, 6, 1, 0, 3, 0, 0);
    add(oh(7), 0, 7, 1, 0, 3, 0, 0);
    add(oh(0), 0, 0, 1, 1, 4, 0, 0);
    add(oh(1), 0, 1, 1, 0, 4, 0, 0);
    add(oh(2), 0, 2, 1, 0, 4, 0, 0);
    add(oh(5), 0, 2, 0, 0, 4, 0, 1);
    add(oh(6), 0, 2, 0, 0, 4, 0, 1);
    add(oh(7), 0, 2, 0, 0, 4, 0, 1);
    add(zero_v, 1, 2, 0, 0, 0, 0, 0);
    add(zero_v, 0, 2, 0, 0, 0, 0, 0);

    // Multi-hot in SYNC with clear_err in the same cycle: the error wins; then clear in IDLE.
    add(oh(0),   0, 0, 0, 0, 0, 0, 0);
    add(multi_v, 1, 0, 0, 0, 0, 1, 0);
    add(zero_v,  0, 0, 0, 0, 0, 1, 0);
    add(zero_v,  1, 0, 0, 0, 0, 0, 0);

    // Stall in SYNC resets the lock count silently; clear_err while locked is harmless.
    add(oh(0), 0, 0, 0, 0, 0, 0, 0);
    add(oh(1), 0, 1, 0, 0, 0, 0, 0);
    add(oh(2), 0, 2, 0, 0, 0, 0, 0);
    add(oh(2), 0, 2, 0, 0, 0, 0, 0);
    add(oh(2), 0, 2, 0, 0, 0, 0, 0);
    add(oh(3), 0, 3, 0, 0, 0, 0, 0);
    add(oh(4), 0, 4, 0, 0, 0, 0, 0);
    add(oh(5), 0, 5, 0, 0, 0, 0, 0);
    add(oh(6), 0, 6, 1, 0, 0, 0, 0);
    add(oh(7), 1, 7, 1, 0, 0, 0, 0);
    add(oh(0), 0, 0, 1, 1, 1, 0, 0);
    add(oh(1), 0, 1, 1, 0, 1, 0, 0);
    add(oh(2), 0, 2, 1, 0, 1, 0, 0);
    add(oh(3), 0, 3, 1, 0, 1, 0, 0);

    // Two bits set while locked: one-hot fault, outputs frozen.
    add(multi_v, 0, 3, 0, 0, 1, 1, 0);
    add(oh(4),   0, 3, 0, 0, 1, 1, 0);
    run_table("main");

    // Reset asserted mid-FAULT takes effect before the next clock edge.
    @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    check_outputs(rst_v, "async_reset");
    @(negedge clock);
    reset   = 1'b0;
    ring_in = '0;

    // Locking on a wrap edge must not produce a lap tick.
    add(zero_v, 0, 0, 0, 0, 0, 0, 0);
    add(oh(4),  0, 4, 0, 0, 0, 0, 0);
    add(oh(5),  0, 5, 0, 0, 0, 0, 0);
    add(oh(6),  0, 6, 0, 0, 0, 0, 0);
    add(oh(7),  0, 7, 0, 0, 0, 0, 0);
    add(oh(0),  0, 0, 1, 0, 0, 0, 0);
    add(oh(1),  0, 1, 1, 0, 0, 0, 0);
    run_table("wrap_lock");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
